// File: rtl/prompt_capture.sv
// prompt_capture: turns HID keycodes into an ASCII prompt line. The line can be
// edited with backspace. Enter streams the line to inference as a byte stream.
// After the last byte, execute pulses and editing waits for generate_complete.
// Optional build macro: UPPERCASE_SHIFT_EN makes shift (0xE1/0xE5 in any slot)
// produce upper-case letters.
//
// Handshake: a byte moves on every rising edge where ascii_valid && ascii_ready.
// Once ascii_valid is raised it stays high, and ascii_data stays stable, until
// that byte has been accepted. Valid is never withdrawn early.
module prompt_capture #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_rtl_0,
  input  logic [31:0]      keycode0_gpio,
  input  logic             ascii_ready,
  input  logic             generate_complete,
  output logic             ascii_valid,
  output logic [7:0]       ascii_data,
  output logic             execute,
  output logic [LEN_W-1:0] prompt_len,
  output logic             overflow,
  output logic [1:0]       state_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    EDIT     = 2'd0,
    STREAM   = 2'd1,
    WAIT_GEN = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       line_buf [MAX_LEN];
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] rd_idx;
  logic [7:0]       prev_key;
  logic [7:0]       cur;
  logic [7:0]       ch;
  logic             shift;
  logic             press;
  logic             printable;
  logic             is_enter;
  logic             is_bksp;
  logic             wr_en;
  logic             last;

  assign cur = keycode0_gpio[7:0];

`ifdef UPPERCASE_SHIFT_EN
  // Shift is held when any of the four report slots carries a shift usage code.
  always_comb begin
    shift = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode0_gpio[8*i +: 8] == 8'hE1 || keycode0_gpio[8*i +: 8] == 8'hE5) begin
        shift = 1'b1;
      end
    end
  end
  // Shift codes in slot0 are modifiers, never key presses.
  assign press = (cur != 8'h00) && (cur != prev_key) && (cur != 8'hE1) && (cur != 8'hE5);
`else
  logic unused_slots;
  assign unused_slots = ^keycode0_gpio[31:8];
  assign shift = 1'b0;
  assign press = (cur != 8'h00) && (cur != prev_key);
`endif

  // Keycode to ASCII translation. Unlisted codes are not printable.
  always_comb begin
    printable = 1'b0;
    ch        = 8'h00;
    if (cur >= 8'h04 && cur <= 8'h1D) begin
      printable = 1'b1;
      ch        = (shift ? 8'h41 : 8'h61) + (cur - 8'h04);
    end else if (cur >= 8'h1E && cur <= 8'h26) begin
      printable = 1'b1;
      ch        = 8'h31 + (cur - 8'h1E);
    end else if (cur == 8'h27) begin
      printable = 1'b1;
      ch        = 8'h30;
    end else if (cur == 8'h2C) begin
      printable = 1'b1;
      ch        = 8'h20;
    end else if (cur == 8'h36) begin
      printable = 1'b1;
      ch        = 8'h2C;
    end else if (cur == 8'h37) begin
      printable = 1'b1;
      ch        = 8'h2E;
    end
  end

  assign is_enter = press && (cur == 8'h28);
  assign is_bksp  = press && (cur == 8'h2A);
  assign wr_en    = (state == EDIT) && press && printable && (len != FULL);
  assign last     = (rd_idx == len - ONE);

  // Line storage: contents past len are meaningless, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[len[IDX_W-1:0]] <= ch;
    end
  end

  // Main control: edit the line, stream it out, then wait for inference.
  always_ff @(posedge clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state       <= EDIT;
      len         <= '0;
      rd_idx      <= '0;
      prev_key    <= 8'h00;
      ascii_valid <= 1'b0;
      execute     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      prev_key <= cur;
      execute  <= 1'b0;
      case (state)
        EDIT: begin
          if (press && printable) begin
            if (len != FULL) begin
              len <= len + ONE;
            end else begin
              overflow <= 1'b1;
            end
          end else if (is_bksp) begin
            if (len != '0) begin
              len <= len - ONE;
            end
          end else if (is_enter && (len != '0)) begin
            rd_idx      <= '0;
            ascii_valid <= 1'b1;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (ascii_valid && ascii_ready) begin
            if (last) begin
              ascii_valid <= 1'b0;
              execute     <= 1'b1;
              state       <= WAIT_GEN;
            end else begin
              rd_idx <= rd_idx + ONE;
            end
          end
        end
        WAIT_GEN: begin
          // The execute cycle itself is skipped; sampling starts right after.
          if (generate_complete && !execute) begin
            len      <= '0;
            overflow <= 1'b0;
            rd_idx   <= '0;
            state    <= EDIT;
          end
        end
        default: begin
          ascii_valid <= 1'b0;
          rd_idx      <= '0;
          state       <= EDIT;
        end
      endcase
    end
  end

  assign ascii_data = ascii_valid ? line_buf[rd_idx[IDX_W-1:0]] : 8'h00;
  assign prompt_len = len;
  assign state_o    = state;

endmodule

// File: tb/tb_prompt_capture.sv
// Bench for prompt_capture: random key traffic is applied to a queue-based model
// of the prompt line. Expected stream bytes go into a scoreboard queue. A monitor
// pops them and compares on every accepted byte.
`timescale 1ns/1ps
module tb_prompt_capture;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic [31:0]      keycode0_gpio;
  logic             ascii_ready;
  logic             generate_complete;
  logic             ascii_valid;
  logic [7:0]       ascii_data;
  logic             execute;
  logic [LEN_W-1:0] prompt_len;
  logic             overflow;
  logic [1:0]       state_o;

  prompt_capture #(.MAX_LEN(MAX_LEN)) dut (
    .clk               (clk),
    .reset_rtl_0       (rst_n),
    .keycode0_gpio     (keycode0_gpio),
    .ascii_ready       (ascii_ready),
    .generate_complete (generate_complete),
    .ascii_valid       (ascii_valid),
    .ascii_data        (ascii_data),
    .execute           (execute),
    .prompt_len        (prompt_len),
    .overflow          (overflow),
    .state_o           (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected finish before 500000 ns");
    $fatal(1);
  end

  // ---------------- model and scoreboard state ----------------
  logic [7:0] exp_q[$];     // bytes the DUT must still stream
  logic [7:0] mdl_buf[$];   // the prompt line as the model sees it
  bit         mdl_ovf;
  logic [7:0] mdl_prev;
  int         mode;         // 0 editing, 1 streaming, 2 waiting for inference
  bit         ready_pat[$];
  int         checks;
  int         passes;
  int         exec_count;
  int         exp_exec;
  int         stream_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int ref_char(input logic [31:0] kc);
    int    k;
    bit    sh;
    string digits;
    digits = "1234567890";
    k  = int'(kc[7:0]);
    sh = 1'b0;
`ifdef UPPERCASE_SHIFT_EN
    for (int i = 0; i < 4; i++)
      if (kc[8*i +: 8] == 8'hE1 || kc[8*i +: 8] == 8'hE5) sh = 1'b1;
`endif
    if (k >= 4 && k <= 29) return (sh ? 65 : 97) + (k - 4);
    if (k >= 30 && k <= 39) return int'(digits[k - 30]);
    if (k == 44) return 32;
    if (k == 54) return 44;
    if (k == 55) return 46;
    return -1;
  endfunction

  function automatic bit is_press(input int k);
    bit p;
    p = (k != 0) && (k != int'(mdl_prev));
`ifdef UPPERCASE_SHIFT_EN
    if (k == 'hE1 || k == 'hE5) p = 1'b0;
`endif
    return p;
  endfunction

  function automatic logic [31:0] rand_key();
    logic [31:0] kc;
    int          r;
    kc = 32'h0;
    r  = $urandom_range(0, 9);
    if (r <= 1) kc[7:0] = 8'h00;
    else if (r <= 5) kc[7:0] = 8'($urandom_range(4, 29));
    else if (r == 6) kc[7:0] = 8'($urandom_range(30, 39));
    else if (r == 7) kc[7:0] = ($urandom_range(0, 1) == 0) ? 8'h2C : 8'h36;
    else if (r == 8) kc[7:0] = 8'h2A;
    else kc[7:0] = 8'($urandom_range(0, 255));
    if (kc[7:0] == 8'h28) kc[7:0] = 8'h37;
    if ($urandom_range(0, 3) == 0) kc[8*$urandom_range(1, 3) +: 8] = ($urandom_range(0, 1) == 0) ? 8'hE1 : 8'hE5;
    return kc;
  endfunction

  // ---------------- driver tasks ----------------
  // Applies one cycle of keycode input and advances the model by the same cycle.
  task automatic drive_key(input logic [31:0] kc);
    int k;
    int c;
    bit was_edit;
    keycode0_gpio = kc;
    k = int'(kc[7:0]);
    c = ref_char(kc);
    was_edit = (mode == 0);
    if (was_edit && is_press(k)) begin
      if (c >= 0) begin
        if (mdl_buf.size() < MAX_LEN) mdl_buf.push_back(8'(c));
        else mdl_ovf = 1'b1;
      end else if (k == 'h2A) begin
        if (mdl_buf.size() > 0) void'(mdl_buf.pop_back());
      end else if (k == 'h28 && mdl_buf.size() > 0) begin
        foreach (mdl_buf[i]) exp_q.push_back(mdl_buf[i]);
        mode = 1;
      end
    end
    mdl_prev = kc[7:0];
    @(posedge clk);
    #1;
    if (was_edit) begin
      check("prompt_len", 32'(prompt_len), mdl_buf.size());
      check("overflow", 32'(overflow), 32'(mdl_ovf));
      check("state_edit", 32'(state_o), mode);
    end
  endtask

  task automatic type_key(input logic [31:0] kc);
    drive_key(kc);
    drive_key(32'h0);
  endtask

  // Runs the stream until execute shows, using ready_pat first, then random ready.
  task automatic run_stream();
    int n;
    n = 0;
    while (!execute && n < 2000) begin
      if (ready_pat.size() > 0) ascii_ready = ready_pat.pop_front();
      else ascii_ready = 1'($urandom_range(0, 1));
      drive_key($urandom());
      n++;
    end
    stream_cycles = n;
    check("execute_seen", 32'(execute), 1);
    check("stream_drained", exp_q.size(), 0);
    check("state_wait", 32'(state_o), 2);
    ascii_ready = 1'b0;
    mode = 2;
    exp_exec++;
  endtask

  task automatic wait_and_release(input int cycles);
    repeat (cycles) begin
      drive_key($urandom());
      check("wait_len", 32'(prompt_len), mdl_buf.size());
      check("wait_ovf", 32'(overflow), 32'(mdl_ovf));
      check("wait_state", 32'(state_o), 2);
    end
    check("execute_count", exec_count, exp_exec);
    generate_complete = 1'b1;
    drive_key(32'h0);
    generate_complete = 1'b0;
    mdl_buf.delete();
    mdl_ovf = 1'b0;
    mode = 0;
    check("release_state", 32'(state_o), 0);
    check("release_len", 32'(prompt_len), 0);
    check("release_ovf", 32'(overflow), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit         stall_prev;
  logic [7:0] stall_data;
  bit         exec_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      exec_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(ascii_valid), 1);
        check("stall_data", 32'(ascii_data), 32'(stall_data));
      end
      if (ascii_valid && ascii_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got 0x%0h expected no transfer", ascii_data);
        end else begin
          check("stream_byte", 32'(ascii_data), 32'(exp_q.pop_front()));
        end
      end
      if (execute) begin
        check("execute_after_drain", exp_q.size(), 0);
        check("execute_single", 32'(exec_prev), 0);
        exec_count++;
      end
      stall_prev = ascii_valid && !ascii_ready;
      stall_data = ascii_data;
      exec_prev  = execute;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    keycode0_gpio     = 32'h0;
    ascii_ready       = 1'b0;
    generate_complete = 1'b0;
    rst_n             = 1'b0;
    mode              = 0;
    mdl_prev          = 8'h00;
    mdl_ovf           = 1'b0;
    checks = 0; passes = 0; exec_count = 0; exp_exec = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ascii_valid), 0);
    check("rst_data", 32'(ascii_data), 0);
    check("rst_execute", 32'(execute), 0);
    check("rst_len", 32'(prompt_len), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_state", 32'(state_o), 0);
    rst_n = 1'b1;
    drive_key(32'h0);

    // "hi" with ready tied high: two bytes back to back, then execute.
    drive_key(32'h0B); drive_key(32'h0); drive_key(32'h0C); drive_key(32'h0);
    ready_pat = '{1'b1, 1'b1, 1'b1};
    drive_key(32'h28);
    run_stream();
    check("hi_stream_cycles", stream_cycles, 2);
    wait_and_release(3);

    // Held key gives one press; backspace never underflows.
    repeat (50) drive_key(32'h04);
    drive_key(32'h0);
    type_key(32'h2A);
    type_key(32'h2A);
    type_key(32'h2A);
    repeat (50) drive_key(32'h04);
    drive_key(32'h0);
    drive_key(32'h28);
    run_stream();
    wait_and_release(2);

    // Overflow: 65 printable presses, then the full 64-byte stream.
    for (int i = 0; i < 65; i++) type_key(32'($urandom_range(4, 39)));
    for (int i = 0; i < 70; i++) ready_pat.push_back(1'b1);
    drive_key(32'h28);
    run_stream();
    check("full_stream_cycles", stream_cycles, MAX_LEN);
    ready_pat.delete();
    wait_and_release(4);

    // "abc" with a stall on 'b'.
    type_key(32'h04); type_key(32'h05); type_key(32'h06);
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drive_key(32'h28);
    run_stream();
    wait_and_release(5);

    // Shift held in slot1 with 'a' in slot0.
    drive_key(32'h0000_E104);
    drive_key(32'h0);
    drive_key(32'h28);
    run_stream();
    wait_and_release(2);

    // Enter on an empty line is ignored.
    type_key(32'h28);

    // Random editing rounds.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(10, 40)) drive_key(rand_key());
      drive_key(32'h0);
      drive_key(32'h28);
      if (mode == 1) begin
        run_stream();
        wait_and_release($urandom_range(2, 6));
      end
    end

    // Reset in the middle of a stall-held stream.
    if (mode != 0) wait_and_release(2);
    type_key(32'h1B); type_key(32'h1C); type_key(32'h1D);
    ascii_ready = 1'b0;
    drive_key(32'h28);
    drive_key(32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ascii_valid), 0);
    check("midrst_execute", 32'(execute), 0);
    check("midrst_state", 32'(state_o), 0);
    check("midrst_len", 32'(prompt_len), 0);
    exp_q.delete();
    mdl_buf.delete();
    mdl_ovf  = 1'b0;
    mdl_prev = 8'h00;
    mode     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ascii_ready = 1'b1;
    repeat (10) drive_key(32'h0);
    check("midrst_no_execute", exec_count, exp_exec);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
